multiplier_datapath: RTL and testbench

Datapath half of the 32×32 unsigned shift-add multiplier; it sits directly downstream of the multiplier Control unit. It consumes Control's `wrctrl`, `strctrl`, `addctrl` and `ready`, holds the multiplicand and the 65-bit running product, and returns the product LSB as `lsb` to steer Control's add/no-add decision. When Control raises `ready`, the block freezes and presents the 64-bit result with a one-cycle `done` pulse.

---
 rtl/multiplier_datapath_if.sv | 39 +++
 rtl/multiplier_datapath.sv | 66 ++++++
 tb/tb_multiplier_datapath.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/multiplier_datapath_if.sv
// rtl/multiplier_datapath_if.sv - Control-to-datapath bundle for the shift-add multiplier
//
// Purpose: groups the Control handshake, operand inputs and result outputs of
// multiplier_datapath so Control (master) and the datapath (slave) share one port.
// Signals:
//    wrctrl       master->slave  load operands
//    strctrl      master->slave  1 = store ALU result into upper half, 0 = shift right
//    addctrl[5:0] master->slave  ALU op code
//    ready        master->slave  Control finished; freezes datapath
//    multiplicand master->slave  operand A
//    multiplier   master->slave  operand B
//    lsb          slave->master  prod[0], steers Control's add/no-add decision
//    product      slave->master  low 2*WIDTH bits of running product
//    busy         slave->master  multiply in progress
//    done         slave->master  one-cycle completion pulse
interface multiplier_datapath_if #(
   parameter int WIDTH = 32
);
   logic                 wrctrl;
   logic                 strctrl;
   logic [5:0]           addctrl;
   logic                 ready;
   logic [WIDTH-1:0]     multiplicand;
   logic [WIDTH-1:0]     multiplier;
   logic                 lsb;
   logic [2*WIDTH-1:0]   product;
   logic                 busy;
   logic                 done;

   modport master (
      output wrctrl, strctrl, addctrl, ready, multiplicand, multiplier,
      input  lsb, product, busy, done
   );

   modport slave (
      input  wrctrl, strctrl, addctrl, ready, multiplicand, multiplier,
      output lsb, product, busy, done
   );
endinterface

// File: rtl/multiplier_datapath.sv
// rtl/multiplier_datapath.sv - Datapath half of the 32x32 unsigned shift-add multiplier
//
// Purpose: holds the multiplicand and the (2*WIDTH+1)-bit running product, performs
// one add or one shift per cycle under Control's direction, and presents the
// result with a one-cycle done pulse when Control raises ready.
// Ports:
//    clk    in   single clock, rising edge
//    reset  in   asynchronous, active-low; clears all state
//    bus    slave modport of multiplier_datapath_if (see that file for signals)
module multiplier_datapath #(
   parameter int         WIDTH  = 32,
   parameter logic [5:0] ADD_OP = 6'd27
) (
   input  logic                 clk,
   input  logic                 reset,
   multiplier_datapath_if.slave bus
);

   logic [WIDTH-1:0]   mcand;
   // Bit 2*WIDTH is the adder carry; it must survive until the following shift
   // moves it into the top of the 2*WIDTH-bit result.
   logic [2*WIDTH:0]   prod;
   logic               busy_q;
   logic               done_q;
   logic [WIDTH:0]     alu_result;

   always_comb begin
      alu_result = {1'b0, prod[2*WIDTH-1:WIDTH]};
      if (bus.addctrl == ADD_OP) begin
         alu_result = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mcand  <= '0;
         prod   <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (bus.wrctrl) begin
            // A load always wins, even mid-multiply: the partial product is discarded.
            mcand  <= bus.multiplicand;
            prod   <= {{(WIDTH+1){1'b0}}, bus.multiplier};
            busy_q <= 1'b1;
         end else if (busy_q) begin
            if (bus.ready) begin
               busy_q <= 1'b0;
               done_q <= 1'b1;
            end else if (bus.strctrl) begin
               prod[2*WIDTH:WIDTH] <= alu_result;
            end else begin
               prod <= prod >> 1;
            end
         end
         // Idle: Control's strctrl/addctrl/ready are ignored so the last result holds.
      end
   end

   assign bus.lsb     = prod[0];
   assign bus.product = prod[2*WIDTH-1:0];
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;

endmodule

// File: tb/tb_multiplier_datapath.sv
// tb/tb_multiplier_datapath.sv - Self-checking bench for multiplier_datapath
module tb_multiplier_datapath;

   localparam int         W      = 32;
   localparam logic [5:0] ADD_OP = 6'd27;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;

   multiplier_datapath_if #(.WIDTH(W)) bus ();

   multiplier_datapath #(.WIDTH(W), .ADD_OP(ADD_OP)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: the mathematical product of two unsigned operands.
   function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [2*W-1:0] r;
      r = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      return r;
   endfunction

   task automatic drive_idle();
      bus.wrctrl  = 1'b0;
      bus.strctrl = 1'b0;
      bus.addctrl = 6'd0;
      bus.ready   = 1'b0;
   endtask

   // Leaves the bench at the negedge after the load edge.
   task automatic do_load(input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      bus.wrctrl       = 1'b1;
      bus.multiplicand = a;
      bus.multiplier   = b;
      bus.ready        = 1'b0;
      bus.strctrl      = 1'b0;
      @(negedge clk);
      bus.wrctrl = 1'b0;
   endtask

   // One Control iteration: add-or-pass step, then shift step.
   task automatic do_iter();
      bus.strctrl = 1'b1;
      bus.addctrl = bus.lsb ? ADD_OP : 6'd0;
      @(negedge clk);
      bus.strctrl = 1'b0;
      bus.addctrl = 6'd0;
      @(negedge clk);
   endtask

   // Raise ready for one edge; returns at the negedge where done should be high.
   task automatic do_finish();
      bus.ready = 1'b1;
      @(negedge clk);
      bus.ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         bus.wrctrl       = 1'($urandom);
         bus.strctrl      = 1'($urandom);
         bus.addctrl      = 6'($urandom);
         bus.ready        = 1'($urandom);
         bus.multiplicand = $urandom;
         bus.multiplier   = $urandom;
         #1;
         n_checks++;
         if (bus.product !== '0 || bus.lsb !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold: product=%h lsb=%b busy=%b done=%b, required all 0",
                     bus.product, bus.lsb, bus.busy, bus.done);
         end
      end
      @(negedge clk);
      drive_idle();
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         bus.strctrl = 1'($urandom);
         bus.addctrl = ($urandom_range(0, 1) != 0) ? ADD_OP : 6'd0;
         bus.ready   = 1'($urandom);
         n_checks++;
         if (bus.product !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_idle: product=%h busy=%b done=%b, required all 0",
                     bus.product, bus.busy, bus.done);
         end
      end
      drive_idle();
   endtask

   task automatic test_basic();
      do_load(32'd5, 32'd3);
      n_checks++;
      if (bus.busy !== 1'b1 || bus.lsb !== 1'b1) begin
         n_fail++;
         $display("FAIL basic_load: busy=%b lsb=%b, required busy=1 lsb=1", bus.busy, bus.lsb);
      end
      for (int k = 0; k < W; k++) do_iter();
      do_finish();
      n_checks++;
      if (bus.product !== 64'd15 || bus.done !== 1'b1 || bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_result: product=%0d done=%b busy=%b, required 15 1 0",
                  bus.product, bus.done, bus.busy);
      end
   endtask

   // Runs straight after test_basic: ready held high, Control idle codes toggling.
   task automatic test_idle();
      for (int i = 0; i < 10; i++) begin
         bus.ready   = 1'b1;
         bus.strctrl = 1'($urandom);
         bus.addctrl = (i % 2 == 0) ? ADD_OP : 6'd0;
         @(negedge clk);
         n_checks++;
         if (bus.product !== 64'd15 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_hold[%0d]: product=%0d done=%b busy=%b, required 15 0 0",
                     i, bus.product, bus.done, bus.busy);
         end
      end
      drive_idle();
   endtask

   task automatic test_carry();
      do_load(32'hFFFF_FFFF, 32'hFFFF_FFFF);
      for (int k = 0; k < W; k++) do_iter();
      do_finish();
      n_checks++;
      if (bus.product !== 64'hFFFF_FFFE_0000_0001 || bus.done !== 1'b1) begin
         n_fail++;
         $display("FAIL carry_result: product=%h done=%b, required fffffffe00000001 1",
                  bus.product, bus.done);
      end
   endtask

   task automatic test_restart();
      do_load($urandom, $urandom);
      for (int k = 0; k < 10; k++) do_iter();
      do_load(32'd7, 32'd9);
      for (int k = 0; k < W; k++) do_iter();
      do_finish();
      n_checks++;
      if (bus.product !== 64'd63 || bus.done !== 1'b1) begin
         n_fail++;
         $display("FAIL restart_result: product=%0d done=%b, required 63 1", bus.product, bus.done);
      end
   endtask

   task automatic test_abort();
      logic saw_done;
      do_load(32'hDEAD_BEEF, 32'h1234_5677);
      for (int k = 0; k < 5; k++) do_iter();
      bus.strctrl = 1'b1;
      bus.addctrl = ADD_OP;
      #1 reset = 1'b0;
      #1;
      n_checks++;
      if (bus.product !== '0 || bus.lsb !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_async: product=%h lsb=%b busy=%b done=%b, required all 0",
                  bus.product, bus.lsb, bus.busy, bus.done);
      end
      @(negedge clk);
      reset = 1'b1;
      drive_idle();
      saw_done = 1'b0;
      for (int i = 0; i < 6; i++) begin
         bus.ready = 1'b1;
         @(negedge clk);
         if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.product !== '0) saw_done = 1'b1;
      end
      drive_idle();
      n_checks++;
      if (saw_done !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_no_done: state changed after abort (saw=%b), required 0", saw_done);
      end
   endtask

   task automatic test_priority();
      logic [W-1:0] a;
      logic [W-1:0] b;
      do_load($urandom, $urandom);
      for (int k = 0; k < 3; k++) do_iter();
      a = $urandom;
      b = $urandom | 32'h1;
      @(negedge clk);
      bus.wrctrl       = 1'b1;
      bus.ready        = 1'b1;
      bus.multiplicand = a;
      bus.multiplier   = b;
      @(negedge clk);
      bus.wrctrl = 1'b0;
      bus.ready  = 1'b0;
      n_checks++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.lsb !== b[0]) begin
         n_fail++;
         $display("FAIL priority_load: busy=%b done=%b lsb=%b, required 1 0 %b",
                  bus.busy, bus.done, bus.lsb, b[0]);
      end
      for (int k = 0; k < W; k++) do_iter();
      do_finish();
      n_checks++;
      if (bus.product !== ref_mul(a, b)) begin
         n_fail++;
         $display("FAIL priority_result: product=%h, required %h", bus.product, ref_mul(a, b));
      end
   endtask

   task automatic test_random();
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] b_shift;
      for (int t = 0; t < 6; t++) begin
         a = $urandom;
         b = $urandom;
         if (t == 0) a = '0;
         if (t == 1) b = 32'h8000_0000;
         do_load(a, b);
         b_shift = b;
         for (int k = 0; k < W; k++) begin
            // Before iteration k Control must see multiplier bit k.
            n_checks++;
            if (bus.lsb !== b_shift[0]) begin
               n_fail++;
               $display("FAIL random_lsb[%0d.%0d]: lsb=%b, required %b", t, k, bus.lsb, b_shift[0]);
            end
            b_shift = b_shift >> 1;
            do_iter();
         end
         do_finish();
         n_checks++;
         if (bus.product !== ref_mul(a, b) || bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL random_result[%0d]: product=%h done=%b busy=%b, required %h 1 0",
                     t, bus.product, bus.done, bus.busy, ref_mul(a, b));
         end
         @(negedge clk);
         n_checks++;
         if (bus.done !== 1'b0 || bus.product !== ref_mul(a, b)) begin
            n_fail++;
            $display("FAIL random_done_pulse[%0d]: done=%b product=%h, required 0 %h",
                     t, bus.done, bus.product, ref_mul(a, b));
         end
      end
   endtask

   initial begin
      n_checks         = 0;
      n_fail           = 0;
      reset            = 1'b0;
      bus.multiplicand = '0;
      bus.multiplier   = '0;
      drive_idle();
      test_reset();
      test_basic();
      test_idle();
      test_carry();
      test_restart();
      test_abort();
      test_priority();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
